// File: rtl/store_queue_pkg.sv
// rtl/store_queue_pkg.sv - shared sizes, entry type and stall encoding for the store queue
package store_queue_pkg;

  localparam int SQ_DEPTH   = 16;
  localparam int SQ_IDX     = 4;
  localparam int XLEN       = 32;
  localparam int COMMIT_MAX = 4;
  localparam int CNT_W      = SQ_IDX + 1;
  localparam int CCNT_W     = $clog2(COMMIT_MAX) + 1;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  typedef struct packed {
    logic            valid;
    logic            filled;
    logic            committed;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    mem_size_e       size;
  } sq_entry_packet_t;

  // Credits to per-lane stall mask; lane 2 is oldest and is the last to stall.
  function automatic logic [2:0] stall_enc(input logic [CNT_W-1:0] credits);
    logic [2:0] enc;
    if (credits == CNT_W'(0))      enc = 3'b111;
    else if (credits == CNT_W'(1)) enc = 3'b011;
    else if (credits == CNT_W'(2)) enc = 3'b001;
    else                           enc = 3'b000;
    return enc;
  endfunction

endpackage

// File: rtl/store_queue.sv
// rtl/store_queue.sv - circular store queue: 3-wide allocate, execute fill, in-order commit and D-cache drain
module store_queue
  import store_queue_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            dispatch_valid,
  output logic [2:0]            dispatch_stall,
  output logic [3*SQ_IDX-1:0]   dispatch_index,
  input  logic                  exec_valid,
  input  logic [SQ_IDX-1:0]     exec_idx,
  input  logic [XLEN-1:0]       exec_addr,
  input  logic [XLEN-1:0]       exec_data,
  input  logic [1:0]            exec_size,
  input  logic [1:0]            retire_num,
  input  logic                  squash,
  output logic [2:0]            sq_stall,
  output logic                  dc_req_valid,
  output logic [XLEN-1:0]       dc_req_addr,
  output logic [XLEN-1:0]       dc_req_data,
  output logic [1:0]            dc_req_size,
  input  logic                  dc_req_ready
);

  sq_entry_packet_t  entries_q [SQ_DEPTH];
  sq_entry_packet_t  entries_d [SQ_DEPTH];
  logic [SQ_IDX-1:0] head_q, head_d;
  logic [SQ_IDX-1:0] cmt_q, cmt_d;
  logic [SQ_IDX-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CCNT_W-1:0] ccount_q, ccount_d;
  logic [2:0]        grant;
  logic [1:0]        n_grant;
  logic              drain;

  assign dc_req_valid = entries_q[head_q].valid & entries_q[head_q].committed;
  assign dc_req_addr  = entries_q[head_q].addr;
  assign dc_req_data  = entries_q[head_q].data;
  assign dc_req_size  = entries_q[head_q].size;
  assign drain        = dc_req_valid & dc_req_ready;

  // Credits come from registered counts only, so a same-cycle drain frees nothing yet.
  assign dispatch_stall = stall_enc(CNT_W'(SQ_DEPTH) - count_q);
  assign sq_stall       = stall_enc(CNT_W'(COMMIT_MAX) - CNT_W'(ccount_q));

  assign grant   = dispatch_valid & ~dispatch_stall & {3{~squash}} & {3{reset}};
  assign n_grant = {1'b0, grant[2]} + {1'b0, grant[1]} + {1'b0, grant[0]};

  always_comb begin
    dispatch_index = '0;
    for (int k = 0; k < 3; k++) begin
      if (grant[2-k]) dispatch_index[(2-k)*SQ_IDX +: SQ_IDX] = tail_q + SQ_IDX'(k);
    end
  end

  always_comb begin
    entries_d = entries_q;

    for (int k = 0; k < 3; k++) begin
      if (grant[2-k]) begin
        entries_d[tail_q + SQ_IDX'(k)]       = '0;
        entries_d[tail_q + SQ_IDX'(k)].valid = 1'b1;
      end
    end

    if (exec_valid && !squash && entries_q[exec_idx].valid) begin
      entries_d[exec_idx].filled = 1'b1;
      entries_d[exec_idx].addr   = exec_addr;
      entries_d[exec_idx].data   = exec_data;
      entries_d[exec_idx].size   = mem_size_e'(exec_size);
    end

    for (int k = 0; k < 3; k++) begin
      if (2'(k) < retire_num) entries_d[cmt_q + SQ_IDX'(k)].committed = 1'b1;
    end

    // Retire is folded in above, so only the speculative tail beyond the new cmt is dropped.
    if (squash) begin
      for (int j = 0; j < SQ_DEPTH; j++) begin
        if (entries_d[j].valid && !entries_d[j].committed) entries_d[j] = '0;
      end
    end

    if (drain) entries_d[head_q] = '0;

    head_d   = head_q + SQ_IDX'(drain);
    cmt_d    = cmt_q + SQ_IDX'(retire_num);
    ccount_d = ccount_q + CCNT_W'(retire_num) - CCNT_W'(drain);

    if (squash) begin
      tail_d  = cmt_d;
      count_d = CNT_W'(ccount_d);
    end else begin
      tail_d  = tail_q + SQ_IDX'(n_grant);
      count_d = count_q + CNT_W'(n_grant) - CNT_W'(drain);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SQ_DEPTH; i++) entries_q[i] <= '0;
      head_q   <= '0;
      cmt_q    <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      ccount_q <= '0;
    end else begin
      for (int i = 0; i < SQ_DEPTH; i++) entries_q[i] <= entries_d[i];
      head_q   <= head_d;
      cmt_q    <= cmt_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      ccount_q <= ccount_d;
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// tb/tb_store_queue.sv - randomized scoreboard bench for store_queue against an in-order store list model
`timescale 1ns/1ps
module tb_store_queue;
  import store_queue_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  dispatch_valid;
  logic [2:0]  dispatch_stall;
  logic [11:0] dispatch_index;
  logic        exec_valid;
  logic [3:0]  exec_idx;
  logic [31:0] exec_addr, exec_data;
  logic [1:0]  exec_size;
  logic [1:0]  retire_num;
  logic        squash;
  logic [2:0]  sq_stall;
  logic        dc_req_valid;
  logic [31:0] dc_req_addr, dc_req_data;
  logic [1:0]  dc_req_size;
  logic        dc_req_ready;

  store_queue dut (
    .clock(clock), .reset(reset),
    .dispatch_valid(dispatch_valid), .dispatch_stall(dispatch_stall), .dispatch_index(dispatch_index),
    .exec_valid(exec_valid), .exec_idx(exec_idx), .exec_addr(exec_addr), .exec_data(exec_data),
    .exec_size(exec_size), .retire_num(retire_num), .squash(squash), .sq_stall(sq_stall),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data),
    .dc_req_size(dc_req_size), .dc_req_ready(dc_req_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          slot;
    bit          filled;
    bit          committed;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } rec_t;

  typedef struct {
    logic [2:0]  dstall;
    logic [11:0] didx;
    logic [2:0]  sstall;
    logic        dcv;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } exp_t;

  rec_t mq[$];
  exp_t exp_q[$];
  int   tail = 0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int n_committed();
    int n = 0;
    foreach (mq[i]) if (mq[i].committed) n++;
    return n;
  endfunction

  function automatic exp_t model_out(input logic [2:0] dv, input logic sq);
    exp_t e;
    int free, cred, ng;
    free = 16 - mq.size();
    cred = 4 - n_committed();
    ng = $countones(dv);
    if (ng > free) ng = free;
    if (sq) ng = 0;
    e.dstall = 3'b111 >> ((free > 3) ? 3 : free);
    e.sstall = 3'b111 >> ((cred > 3) ? 3 : cred);
    e.didx = '0;
    for (int k = 0; k < ng; k++) e.didx[(2-k)*4 +: 4] = 4'((tail + k) % 16);
    e.dcv  = (mq.size() > 0) && mq[0].committed;
    e.addr = e.dcv ? mq[0].addr : 32'h0;
    e.data = e.dcv ? mq[0].data : 32'h0;
    e.size = e.dcv ? mq[0].size : 2'b00;
    return e;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dispatch_stall", 32'(dispatch_stall), 32'(e.dstall));
        chk("dispatch_index", 32'(dispatch_index), 32'(e.didx));
        chk("sq_stall", 32'(sq_stall), 32'(e.sstall));
        chk("dc_req_valid", 32'(dc_req_valid), 32'(e.dcv));
        if (e.dcv) begin
          chk("dc_req_addr", dc_req_addr, e.addr);
          chk("dc_req_data", dc_req_data, e.data);
          chk("dc_req_size", 32'(dc_req_size), 32'(e.size));
        end
      end
    end
  end

  task automatic drive_idle();
    dispatch_valid = 3'b000; exec_valid = 1'b0; exec_idx = '0; exec_addr = '0;
    exec_data = '0; exec_size = 2'b00; retire_num = 2'b00; squash = 1'b0; dc_req_ready = 1'b0;
  endtask

  // One cycle: pick legal inputs from model state, queue the expected outputs, then advance the model.
  task automatic do_cycle(input int p_disp, input int p_ready, input int p_sq, input bit first);
    logic [2:0]  dv;
    logic [3:0]  eidx;
    logic        ev, sq, rdy, drain;
    logic [31:0] ea, ed;
    logic [1:0]  es, rn;
    int          nc, free, maxr, fr, ng;
    int          cand[$];
    rec_t        r;
    exp_t        e;

    nc   = n_committed();
    free = 16 - mq.size();
    case ($urandom_range(3, 0))
      0:       dv = 3'b000;
      1:       dv = 3'b100;
      2:       dv = 3'b110;
      default: dv = 3'b111;
    endcase
    if ($urandom_range(99, 0) >= p_disp) dv = 3'b000;
    if (first) dv = 3'b111;

    maxr = 4 - nc;
    if (maxr > 3) maxr = 3;
    fr = 0;
    for (int i = nc; i < mq.size(); i++) begin
      if (!mq[i].filled) break;
      fr++;
    end
    if (fr < maxr) maxr = fr;
    rn = 2'($urandom_range(maxr, 0));

    ev = 1'b0; eidx = '0;
    ea = $urandom; ed = $urandom; es = 2'($urandom_range(2, 0));
    foreach (mq[i]) if (!mq[i].filled) cand.push_back(mq[i].slot);
    if (cand.size() > 0 && $urandom_range(9, 0) < 7) begin
      ev = 1'b1;
      eidx = 4'(cand[$urandom_range(cand.size() - 1, 0)]);
    end else if (mq.size() < 16 && $urandom_range(9, 0) < 3) begin
      ev = 1'b1;
      eidx = 4'((tail + $urandom_range(15 - mq.size(), 0)) % 16);
    end

    sq  = ($urandom_range(99, 0) < p_sq);
    rdy = ($urandom_range(99, 0) < p_ready);

    assert (dv inside {3'b000, 3'b100, 3'b110, 3'b111});
    assert (int'(rn) <= maxr);

    dispatch_valid = dv; exec_valid = ev; exec_idx = eidx; exec_addr = ea; exec_data = ed;
    exec_size = es; retire_num = rn; squash = sq; dc_req_ready = rdy;

    e = model_out(dv, sq);
    exp_q.push_back(e);

    drain = e.dcv && rdy;
    ng = $countones(dv);
    if (ng > free) ng = free;
    if (sq) ng = 0;
    for (int k = 0; k < int'(rn); k++) mq[nc + k].committed = 1'b1;
    if (ev && !sq) begin
      foreach (mq[i]) begin
        if (mq[i].slot == int'(eidx)) begin
          mq[i].filled = 1'b1; mq[i].addr = ea; mq[i].data = ed; mq[i].size = es;
        end
      end
    end
    if (drain) void'(mq.pop_front());
    for (int k = 0; k < ng; k++) begin
      r.slot = (tail + k) % 16; r.filled = 1'b0; r.committed = 1'b0;
      r.addr = '0; r.data = '0; r.size = 2'b00;
      mq.push_back(r);
    end
    tail = (tail + ng) % 16;
    if (sq) begin
      while (mq.size() > 0 && !mq[mq.size() - 1].committed) begin
        void'(mq.pop_back());
        tail = (tail + 15) % 16;
      end
    end
  endtask

  initial begin
    int guard;
    reset = 1'b0;
    drive_idle();
    repeat (2) @(posedge clock);
    #1;
    exp_q.push_back(model_out(3'b000, 1'b0));
    @(posedge clock);
    #1;
    reset = 1'b1;
    do_cycle(100, 0, 0, 1'b1);

    for (int i = 0; i < 300; i++) begin @(posedge clock); #1; do_cycle(80, 10, 0, 1'b0); end
    for (int i = 0; i < 1500; i++) begin @(posedge clock); #1; do_cycle(50, 50, 3, 1'b0); end
    for (int i = 0; i < 500; i++) begin @(posedge clock); #1; do_cycle(40, 90, 2, 1'b0); end

    // Build a held drain request, then pull reset between edges.
    guard = 0;
    while (!(mq.size() > 0 && mq[0].committed) && guard < 300) begin
      @(posedge clock); #1; do_cycle(60, 0, 0, 1'b0); guard++;
    end
    @(posedge clock);
    #1;
    dispatch_valid = 3'b111;
    dc_req_ready = 1'b0;
    chk("dc_req_valid_before_reset", 32'(dc_req_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("reset_dc_req_valid", 32'(dc_req_valid), 32'd0);
    chk("reset_dc_req_addr", dc_req_addr, 32'h0);
    chk("reset_dc_req_data", dc_req_data, 32'h0);
    chk("reset_dispatch_stall", 32'(dispatch_stall), 32'd0);
    chk("reset_dispatch_index", 32'(dispatch_index), 32'd0);
    chk("reset_sq_stall", 32'(sq_stall), 32'd0);
    mq.delete();
    tail = 0;
    drive_idle();
    @(posedge clock);
    #1;
    reset = 1'b1;
    do_cycle(100, 0, 0, 1'b1);
    for (int i = 0; i < 400; i++) begin @(posedge clock); #1; do_cycle(50, 50, 3, 1'b0); end

    @(posedge clock);
    #1;
    drive_idle();
    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
